// File: rtl/mme_pkg.sv
// Shared width arithmetic for the matrix-multiply PE tail: clog2, derived widths,
// and the node layout of the pipelined adder tree.
package mme_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // A single lane still gets one register stage so latency is never zero.
  function automatic int tree_levels(input int n_inputs);
    return (clog2(n_inputs) < 1) ? 1 : clog2(n_inputs);
  endfunction

  function automatic int tree_width(input int width, input int n_inputs);
    return width + clog2(n_inputs);
  endfunction

  function automatic int res_width(input int width, input int n_inputs, input int acc_len);
    return tree_width(width, n_inputs) + clog2(acc_len);
  endfunction

  function automatic int cnt_width(input int acc_len);
    return (clog2(acc_len) < 1) ? 1 : clog2(acc_len);
  endfunction

  // Elements alive at tree level lvl (level 0 = raw lanes); pairs halve, odd one passes.
  function automatic int level_count(input int n_inputs, input int lvl);
    return (n_inputs + (1 << lvl) - 1) >> lvl;
  endfunction

  // Bit offset of level lvl in the flattened node vector; level k elements are width+k wide.
  function automatic int node_offset(input int width, input int n_inputs, input int lvl);
    int off;
    off = 0;
    for (int k = 0; k < lvl; k++) begin
      off = off + level_count(n_inputs, k) * (width + k);
    end
    return off;
  endfunction

endpackage

// File: rtl/pipelined_sum_accumulator_if.sv
// Beat/result bundle between a PE datapath and its sum accumulator.
interface pipelined_sum_accumulator_if #(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4,
  parameter int ACC_LEN  = 3
);
  import mme_pkg::*;

  localparam int RES_WIDTH = res_width(WIDTH, N_INPUTS, ACC_LEN);

  logic                      clear;
  logic                      in_valid;
  logic [N_INPUTS*WIDTH-1:0] in_data;
  logic [RES_WIDTH-1:0]      sum;
  logic                      sum_valid;
  logic                      busy;

  modport master (
    output clear,
    output in_valid,
    output in_data,
    input  sum,
    input  sum_valid,
    input  busy
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  in_data,
    output sum,
    output sum_valid,
    output busy
  );

endinterface

// File: rtl/pipelined_adder_tree.sv
// Registered unsigned adder tree: N_INPUTS lanes in, one sum out after L register levels,
// with a valid bit travelling alongside each level.
module pipelined_adder_tree
  import mme_pkg::*;
#(
  parameter int  WIDTH      = 8,
  parameter int  N_INPUTS   = 4,
  localparam int TREE_WIDTH = tree_width(WIDTH, N_INPUTS)
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      clear,
  input  logic                      lane_valid,
  input  logic [N_INPUTS*WIDTH-1:0] lanes,
  output logic [TREE_WIDTH-1:0]     tree_sum,
  output logic                      tree_valid,
  output logic                      tree_busy
);

  localparam int L       = tree_levels(N_INPUTS);
  localparam int IN_BITS = N_INPUTS * WIDTH;
  localparam int TOTAL   = node_offset(WIDTH, N_INPUTS, L + 1);
  localparam int OUT_OFF = node_offset(WIDTH, N_INPUTS, L);

  // All levels live in one flat vector; the lanes occupy the bottom IN_BITS.
  logic [TOTAL-1:0]       nodes;
  logic [TOTAL-1:IN_BITS] nodes_reg;
  logic [TOTAL-1:IN_BITS] nodes_next;
  logic [L-1:0]           vld_reg;

  assign nodes = {nodes_reg, lanes};

  generate
    for (genvar gi = 1; gi <= L; gi++) begin : g_level
      localparam int NIN    = level_count(N_INPUTS, gi - 1);
      localparam int NOUT   = level_count(N_INPUTS, gi);
      localparam int WI     = WIDTH + gi - 1;
      localparam int IN_OFF = node_offset(WIDTH, N_INPUTS, gi - 1);
      localparam int LV_OFF = node_offset(WIDTH, N_INPUTS, gi);

      for (genvar gj = 0; gj < NOUT; gj++) begin : g_node
        if (2 * gj + 1 < NIN) begin : g_pair
          assign nodes_next[LV_OFF + gj*(WI+1) +: WI+1] =
              {1'b0, nodes[IN_OFF + (2*gj)*WI +: WI]} +
              {1'b0, nodes[IN_OFF + (2*gj+1)*WI +: WI]};
        end else begin : g_pass
          assign nodes_next[LV_OFF + gj*(WI+1) +: WI+1] =
              {1'b0, nodes[IN_OFF + (2*gj)*WI +: WI]};
        end
      end
    end
  endgenerate

  // Data registers run freely; only the valid bits decide what the accumulator sees.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      nodes_reg <= '0;
      vld_reg   <= '0;
    end else begin
      nodes_reg <= nodes_next;
      if (clear) begin
        vld_reg <= '0;
      end else begin
        vld_reg <= (vld_reg << 1) | L'(lane_valid);
      end
    end
  end

  assign tree_sum   = nodes[OUT_OFF +: TREE_WIDTH];
  assign tree_valid = vld_reg[L-1];
  assign tree_busy  = |vld_reg;

endmodule

// File: rtl/pipelined_sum_accumulator.sv
// PE output stage: sums lanes per beat through the adder tree, then accumulates
// ACC_LEN valid tree outputs into one overflow-free result.
module pipelined_sum_accumulator
  import mme_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4,
  parameter int ACC_LEN  = 3
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  pipelined_sum_accumulator_if.slave  bus
);

  localparam int TREE_WIDTH = tree_width(WIDTH, N_INPUTS);
  localparam int RES_WIDTH  = res_width(WIDTH, N_INPUTS, ACC_LEN);
  localparam int CNT_W      = cnt_width(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_LEN - 1);

  logic [TREE_WIDTH-1:0] tree_sum;
  logic                  tree_valid;
  logic                  tree_busy;

  logic [RES_WIDTH-1:0]  acc_reg;
  logic [RES_WIDTH-1:0]  acc_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [RES_WIDTH-1:0]  sum_reg;
  logic                  sum_valid_reg;

  // clear also kills the beat presented in the same cycle.
  pipelined_adder_tree #(
    .WIDTH    (WIDTH),
    .N_INPUTS (N_INPUTS)
  ) u_tree (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .clear      (bus.clear),
    .lane_valid (bus.in_valid & ~bus.clear),
    .lanes      (bus.in_data),
    .tree_sum   (tree_sum),
    .tree_valid (tree_valid),
    .tree_busy  (tree_busy)
  );

  always_comb begin
    acc_next = RES_WIDTH'(tree_sum);
    if (cnt_reg != '0) begin
      acc_next = acc_reg + RES_WIDTH'(tree_sum);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      sum_valid_reg <= 1'b0;
    end else if (bus.clear) begin
      // sum_reg deliberately keeps the last completed result.
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sum_valid_reg <= 1'b0;
    end else begin
      sum_valid_reg <= 1'b0;
      if (tree_valid) begin
        acc_reg <= acc_next;
        if (cnt_reg == LAST_BEAT) begin
          sum_reg       <= acc_next;
          sum_valid_reg <= 1'b1;
          cnt_reg       <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.sum       = sum_reg;
  assign bus.sum_valid = sum_valid_reg;
  assign bus.busy      = tree_busy | (cnt_reg != '0);

endmodule

// File: tb/tb_pipelined_sum_accumulator.sv
// Directed vector bench for pipelined_sum_accumulator: default 4-lane/3-beat
// instance plus a 3-lane/1-beat instance for the parameter sweep.
module tb_pipelined_sum_accumulator;

  logic Clock = 1'b0;
  logic Reset_n;

  always #5 Clock = ~Clock;

  pipelined_sum_accumulator_if #(.WIDTH(8), .N_INPUTS(4), .ACC_LEN(3)) bus  ();
  pipelined_sum_accumulator_if #(.WIDTH(8), .N_INPUTS(3), .ACC_LEN(1)) bus3 ();

  pipelined_sum_accumulator #(.WIDTH(8), .N_INPUTS(4), .ACC_LEN(3)) u_dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  pipelined_sum_accumulator #(.WIDTH(8), .N_INPUTS(3), .ACC_LEN(1)) u_dut3 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus3.slave)
  );

  typedef struct {
    string       name;
    bit          sel3;
    logic        vld;
    logic        clr;
    logic [31:0] data;
    logic        exp_sv;
    logic [11:0] exp_sum;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   split_at;

  function automatic void add(input string n, input bit s3, input logic v, input logic c,
                              input logic [31:0] d, input logic esv, input int esum,
                              input logic eb);
    vec_t r;
    r.name     = n;
    r.sel3     = s3;
    r.vld      = v;
    r.clr      = c;
    r.data     = d;
    r.exp_sv   = esv;
    r.exp_sum  = 12'(esum);
    r.exp_busy = eb;
    vecs.push_back(r);
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.in_data   = '0;
    bus3.in_valid = 1'b0;
    bus3.clear    = 1'b0;
    bus3.in_data  = '0;
  endtask

  task automatic apply(input vec_t r, input int idx);
    logic [11:0] got_sum;
    logic        got_sv;
    logic        got_busy;
    idle_inputs();
    if (r.sel3) begin
      bus3.in_valid = r.vld;
      bus3.clear    = r.clr;
      bus3.in_data  = r.data[23:0];
    end else begin
      bus.in_valid = r.vld;
      bus.clear    = r.clr;
      bus.in_data  = r.data;
    end
    @(posedge Clock);
    #1;
    if (r.sel3) begin
      got_sum  = 12'(bus3.sum);
      got_sv   = bus3.sum_valid;
      got_busy = bus3.busy;
    end else begin
      got_sum  = bus.sum;
      got_sv   = bus.sum_valid;
      got_busy = bus.busy;
    end
    checks++;
    if (got_sum !== r.exp_sum || got_sv !== r.exp_sv || got_busy !== r.exp_busy) begin
      errors++;
      $display("FAIL %s[%0d]: got sum=%0d sum_valid=%0b busy=%0b, want sum=%0d sum_valid=%0b busy=%0b",
               r.name, idx, got_sum, got_sv, got_busy, r.exp_sum, r.exp_sv, r.exp_busy);
    end else begin
      $display("ok   %s[%0d]: sum=%0d sum_valid=%0b busy=%0b", r.name, idx, got_sum, got_sv, got_busy);
    end
  endtask

  task automatic check_reset_state(input string n);
    checks++;
    if (bus.sum !== 12'd0 || bus.sum_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus3.sum !== 10'd0 || bus3.sum_valid !== 1'b0 || bus3.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got sum=%0d sum_valid=%0b busy=%0b (n3: %0d %0b %0b), want all 0",
               n, bus.sum, bus.sum_valid, bus.busy, bus3.sum, bus3.sum_valid, bus3.busy);
    end else begin
      $display("ok   %s: outputs at reset values", n);
    end
  endtask

  localparam logic [31:0] FF   = 32'hFFFF_FFFF;
  localparam logic [31:0] VA   = 32'h0403_0201;  // {1,2,3,4}      -> 10
  localparam logic [31:0] VB   = 32'h281E_140A;  // {10,20,30,40}  -> 100
  localparam logic [31:0] VC   = 32'h4EB2_6311;  // {17,99,178,78} -> 372
  localparam logic [31:0] ONES = 32'h0101_0101;
  localparam logic [31:0] H45  = 32'h4545_4545;

  initial begin
    // overflow corner: 3 x 1020 = 3060, single pulse at last accept + 3
    add("ovf", 0, 1, 0, FF, 0, 0,    1);
    add("ovf", 0, 1, 0, FF, 0, 0,    1);
    add("ovf", 0, 1, 0, FF, 0, 0,    1);
    add("ovf", 0, 0, 0, 0,  0, 0,    1);
    add("ovf", 0, 0, 0, 0,  1, 3060, 0);
    add("ovf", 0, 0, 0, 0,  0, 3060, 0);
    // mixed values then back-to-back zero group
    add("mix", 0, 1, 0, VA, 0, 3060, 1);
    add("mix", 0, 1, 0, VB, 0, 3060, 1);
    add("mix", 0, 1, 0, VC, 0, 3060, 1);
    add("mix", 0, 1, 0, 0,  0, 3060, 1);
    add("mix", 0, 1, 0, 0,  1, 482,  1);
    add("mix", 0, 1, 0, 0,  0, 482,  1);
    add("mix", 0, 0, 0, 0,  0, 482,  1);
    add("mix", 0, 0, 0, 0,  1, 0,    0);
    add("mix", 0, 0, 0, 0,  0, 0,    0);
    // gaps of 2 and 5 idle cycles inside a group
    add("gap", 0, 1, 0, VA, 0, 0, 1);
    add("gap", 0, 0, 0, 0,  0, 0, 1);
    add("gap", 0, 0, 0, 0,  0, 0, 1);
    add("gap", 0, 1, 0, VB, 0, 0, 1);
    for (int i = 0; i < 5; i++) add("gap", 0, 0, 0, 0, 0, 0, 1);
    add("gap", 0, 1, 0, VC, 0, 0,   1);
    add("gap", 0, 0, 0, 0,  0, 0,   1);
    add("gap", 0, 0, 0, 0,  1, 482, 0);
    add("gap", 0, 0, 0, 0,  0, 482, 0);
    // clear mid-group with a colliding beat; previous sum retained
    add("clr", 0, 1, 0, FF,   0, 482, 1);
    add("clr", 0, 1, 0, FF,   0, 482, 1);
    add("clr", 0, 1, 1, FF,   0, 482, 0);
    add("clr", 0, 1, 0, ONES, 0, 482, 1);
    add("clr", 0, 1, 0, ONES, 0, 482, 1);
    add("clr", 0, 1, 0, ONES, 0, 482, 1);
    add("clr", 0, 0, 0, 0,    0, 482, 1);
    add("clr", 0, 0, 0, 0,    1, 12,  0);
    add("clr", 0, 0, 0, 0,    0, 12,  0);
    // two beats before an asynchronous reset
    add("rst", 0, 1, 0, H45, 0, 12, 1);
    add("rst", 0, 1, 0, H45, 0, 12, 1);
    split_at = vecs.size();
    // after reset: 3 x 276 = 828, stale beats must not contribute
    add("rst", 0, 1, 0, H45, 0, 0,   1);
    add("rst", 0, 1, 0, H45, 0, 0,   1);
    add("rst", 0, 1, 0, H45, 0, 0,   1);
    add("rst", 0, 0, 0, 0,   0, 0,   1);
    add("rst", 0, 0, 0, 0,   1, 828, 0);
    add("rst", 0, 0, 0, 0,   0, 828, 0);
    // N_INPUTS=3, ACC_LEN=1: every beat completes, latency 3
    add("n3a1", 1, 1, 0, FF, 0, 0,   1);
    add("n3a1", 1, 1, 0, FF, 0, 0,   1);
    add("n3a1", 1, 1, 0, FF, 1, 765, 1);
    add("n3a1", 1, 1, 0, FF, 1, 765, 1);
    add("n3a1", 1, 0, 0, 0,  1, 765, 1);
    add("n3a1", 1, 0, 0, 0,  1, 765, 0);
    add("n3a1", 1, 0, 0, 0,  0, 765, 0);

    Reset_n = 1'b0;
    idle_inputs();
    #2;
    check_reset_state("reset");
    #10;
    Reset_n = 1'b1;

    for (int i = 0; i < split_at; i++) apply(vecs[i], i);

    // assert reset between edges with two beats in flight
    #3;
    Reset_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    #2;
    Reset_n = 1'b1;

    for (int i = split_at; i < vecs.size(); i++) apply(vecs[i], i);

    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
